// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle for keypad_scanner.
// Slave is the scanner; master is the keypad or the bench that drives it.
interface keypad_scanner_if;
  logic [3:0] row_raw;
  logic [3:0] col;
  logic [3:0] q_row_keys;
  logic [3:0] hex_R_out;
  logic       key_valid;

  modport master (
    output row_raw,
    input  col,
    input  q_row_keys,
    input  hex_R_out,
    input  key_valid
  );

  modport slave (
    input  row_raw,
    output col,
    output q_row_keys,
    output hex_R_out,
    output key_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchronizer and hex decode.
// Locks on a pressed key until the rows read zero for SCAN_DIV cycles.
module keypad_scanner #(
  parameter logic [7:0] SCAN_DIV = 8'd200
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.slave   kp
);

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [3:0] s1_q, s1_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [3:0] hex_q, hex_d;
  logic       vld_q, vld_d;
  logic [7:0] cnt_q, cnt_d;
  logic [0:0] st_q, st_d;

  logic       last;
  logic [3:0] col_rot;
  logic [1:0] r_idx;
  logic [1:0] c_idx;
  logic [3:0] hex_dec;

  assign last    = (cnt_q == SCAN_DIV - 8'd1);
  assign col_rot = {col_q[2:0], col_q[3]};

  // lowest-index row wins when several are high
  always_comb begin
    r_idx = 2'd3;
    case (1'b1)
      row_q[0]: r_idx = 2'd0;
      row_q[1]: r_idx = 2'd1;
      row_q[2]: r_idx = 2'd2;
      default:  r_idx = 2'd3;
    endcase
  end

  always_comb begin
    c_idx = 2'd0;
    unique case (1'b1)
      col_q[0]: c_idx = 2'd0;
      col_q[1]: c_idx = 2'd1;
      col_q[2]: c_idx = 2'd2;
      col_q[3]: c_idx = 2'd3;
      default:  c_idx = 2'd0;
    endcase
  end

  always_comb begin
    hex_dec = 4'h0;
    unique case ({r_idx, c_idx})
      4'b00_00: hex_dec = 4'h1;
      4'b00_01: hex_dec = 4'h2;
      4'b00_10: hex_dec = 4'h3;
      4'b00_11: hex_dec = 4'hA;
      4'b01_00: hex_dec = 4'h4;
      4'b01_01: hex_dec = 4'h5;
      4'b01_10: hex_dec = 4'h6;
      4'b01_11: hex_dec = 4'hB;
      4'b10_00: hex_dec = 4'h7;
      4'b10_01: hex_dec = 4'h8;
      4'b10_10: hex_dec = 4'h9;
      4'b10_11: hex_dec = 4'hC;
      4'b11_00: hex_dec = 4'hE;
      4'b11_01: hex_dec = 4'h0;
      4'b11_10: hex_dec = 4'hF;
      4'b11_11: hex_dec = 4'hD;
    endcase
  end

  always_comb begin
    s1_d  = kp.row_raw;
    row_d = s1_q;
    col_d = col_q;
    hex_d = hex_q;
    vld_d = vld_q;
    cnt_d = cnt_q + 8'd1;
    st_d  = st_q;
    if (st_q == ST_SCAN) begin
      if (last) begin
        cnt_d = 8'd0;
        if (row_q == 4'd0) begin
          col_d = col_rot;
        end else begin
          st_d  = ST_LOCK;
          hex_d = hex_dec;
          vld_d = 1'b1;
        end
      end
    end else begin
      // counter measures the current run of all-zero row samples
      if (row_q != 4'd0) begin
        cnt_d = 8'd0;
      end else if (last) begin
        cnt_d = 8'd0;
        st_d  = ST_SCAN;
        vld_d = 1'b0;
        col_d = col_rot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 4'd0;
      row_q <= 4'd0;
      col_q <= 4'b0001;
      hex_q <= 4'd0;
      vld_q <= 1'b0;
      cnt_q <= 8'd0;
      st_q  <= ST_SCAN;
    end else begin
      s1_q  <= s1_d;
      row_q <= row_d;
      col_q <= col_d;
      hex_q <= hex_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign kp.col        = col_q;
  assign kp.q_row_keys = row_q;
  assign kp.hex_R_out  = hex_q;
  assign kp.key_valid  = vld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner against a keypad-level reference model.
// Uses SCAN_DIV = 8 so a full column sweep takes 32 cycles.
module tb_keypad_scanner;

  localparam int DIV = 8;
  localparam logic [3:0] MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(8'(DIV))) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // reference: which column is lit, how long we dwelt there,
  // how long the keys have been released, and what was decoded
  logic [3:0] m_s1, m_q, m_hex;
  int         m_ci, m_dwell, m_zero;
  bit         m_lock;

  always @(posedge clk) begin
    logic [3:0] seen;
    int lr;
    if (reset) begin
      m_s1 = 0; m_q = 0; m_hex = 0;
      m_ci = 0; m_dwell = 0; m_zero = 0; m_lock = 0;
    end else begin
      seen = m_q;
      m_q  = m_s1;
      m_s1 = kp.row_raw;
      if (!m_lock) begin
        m_dwell++;
        if (m_dwell == DIV) begin
          m_dwell = 0;
          if (seen == 0) begin
            m_ci = (m_ci + 1) % 4;
          end else begin
            lr = 0;
            for (int r = 3; r >= 0; r--) if (seen[r]) lr = r;
            m_hex  = MAP[lr*4 + m_ci];
            m_lock = 1;
            m_zero = 0;
          end
        end
      end else begin
        m_zero = (seen == 0) ? m_zero + 1 : 0;
        if (m_zero == DIV) begin
          m_lock = 0; m_zero = 0; m_dwell = 0;
          m_ci = (m_ci + 1) % 4;
        end
      end
    end
  end

  function automatic logic [12:0] dut_v();
    return {kp.col, kp.q_row_keys, kp.hex_R_out, kp.key_valid};
  endfunction

  function automatic logic [12:0] mdl_v();
    return {4'(4'b1 << m_ci), m_q, m_hex, m_lock};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_col(input int t);
    int i;
    for (i = 0; i < 80 && (m_ci != t || m_lock); i++) @(negedge clk);
    checks++;
    if (m_ci != t || m_lock) begin
      fails++;
      $display("FAIL wait_col: col idx %0d, required %0d", m_ci, t);
    end
  endtask

  task automatic test_reset();
    kp.row_raw = 4'd0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (dut_v() !== 13'b0001_0000_0000_0) begin
      fails++;
      $display("FAIL reset: got %b, required %b",
               dut_v(), 13'b0001_0000_0000_0);
    end
  endtask

  task automatic test_scan_rotation();
    logic [3:0] prev;
    int run;
    apply_reset();
    prev = kp.col;
    run = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL scan_model: got %b, required %b", dut_v(), mdl_v());
      end
      if (kp.col === prev) begin
        run++;
      end else begin
        checks++;
        if (run != DIV || kp.col !== {prev[2:0], prev[3]}) begin
          fails++;
          $display("FAIL scan_dwell: col %b after %0d cycles, required %b after %0d",
                   kp.col, run, {prev[2:0], prev[3]}, DIV);
        end
        prev = kp.col;
        run = 1;
      end
    end
  endtask

  task automatic test_lock();
    apply_reset();
    wait_col(1);
    kp.row_raw = 4'b0100;
    for (int i = 0; i < 20 && !m_lock; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL lock_model: got %b, required %b", dut_v(), mdl_v());
      end
    end
    checks++;
    if (dut_v() !== 13'b0010_0100_1000_1) begin
      fails++;
      $display("FAIL lock_key8: got %b, required %b",
               dut_v(), 13'b0010_0100_1000_1);
    end
  endtask

  task automatic test_release();
    int n;
    kp.row_raw = 4'd0;
    repeat (3) @(negedge clk);
    kp.row_raw = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL blip_model: got %b, required %b", dut_v(), mdl_v());
      end
    end
    checks++;
    if (kp.key_valid !== 1'b1 || kp.col !== 4'b0010) begin
      fails++;
      $display("FAIL blip_hold: kv %b col %b, required kv 1 col 0010",
               kp.key_valid, kp.col);
    end
    kp.row_raw = 4'd0;
    n = 0;
    while (n < 20 && kp.key_valid === 1'b1) begin
      @(negedge clk);
      n++;
      checks++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL release_model: got %b, required %b", dut_v(), mdl_v());
      end
    end
    // two sync cycles then DIV zero samples
    checks++;
    if (n != DIV + 2 || kp.col !== 4'b0100 || kp.hex_R_out !== 4'h8) begin
      fails++;
      $display("FAIL release: %0d cycles col %b hex %h, required %0d col 0100 hex 8",
               n, kp.col, kp.hex_R_out, DIV + 2);
    end
  endtask

  task automatic test_multi_row();
    apply_reset();
    wait_col(3);
    kp.row_raw = 4'b1001;
    for (int i = 0; i < 20 && !m_lock; i++) @(negedge clk);
    checks++;
    if ({kp.col, kp.hex_R_out, kp.key_valid} !== 9'b1000_1010_1) begin
      fails++;
      $display("FAIL multi_lock: col %b hex %h kv %b, required col 1000 hex A kv 1",
               kp.col, kp.hex_R_out, kp.key_valid);
    end
    for (int i = 0; i < 10; i++) begin
      kp.row_raw = (i < 5) ? 4'b0010 : 4'b1100;
      @(negedge clk);
      checks++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL multi_hold: got %b, required %b", dut_v(), mdl_v());
      end
    end
    kp.row_raw = 4'd0;
    for (int i = 0; i < 20 && m_lock; i++) @(negedge clk);
    checks++;
    if ({kp.col, kp.hex_R_out, kp.key_valid} !== 9'b0001_1010_0) begin
      fails++;
      $display("FAIL multi_release: col %b hex %h kv %b, required col 0001 hex A kv 0",
               kp.col, kp.hex_R_out, kp.key_valid);
    end
  endtask

  task automatic test_reset_in_lock();
    apply_reset();
    wait_col(2);
    kp.row_raw = 4'b1000;
    for (int i = 0; i < 20 && !m_lock; i++) @(negedge clk);
    checks++;
    if (kp.hex_R_out !== 4'hF || kp.key_valid !== 1'b1) begin
      fails++;
      $display("FAIL lock_keyF: hex %h kv %b, required hex F kv 1",
               kp.hex_R_out, kp.key_valid);
    end
    apply_reset();
    checks++;
    if (dut_v() !== 13'b0001_0000_0000_0) begin
      fails++;
      $display("FAIL reset_in_lock: got %b, required %b",
               dut_v(), 13'b0001_0000_0000_0);
    end
    kp.row_raw = 4'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL post_reset: got %b, required %b", dut_v(), mdl_v());
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    repeat (2) @(negedge clk);
    kp.row_raw = 4'b0001;
    @(negedge clk);
    kp.row_raw = 4'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v() !== mdl_v() || kp.key_valid !== 1'b0) begin
        fails++;
        $display("FAIL glitch: got %b, required %b", dut_v(), mdl_v());
      end
    end
    checks++;
    if (kp.col !== 4'b0010) begin
      fails++;
      $display("FAIL glitch_rotate: col %b, required 0010", kp.col);
    end
  endtask

  task automatic test_random();
    int hold;
    apply_reset();
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        kp.row_raw = ($urandom_range(0, 1) == 0) ? 4'd0
                   : 4'($urandom_range(1, 15));
        hold = $urandom_range(1, 30);
      end
      hold--;
      @(negedge clk);
      checks++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL random[%0d]: got %b, required %b", i, dut_v(), mdl_v());
      end
    end
    kp.row_raw = 4'd0;
  endtask

  initial begin
    test_reset();
    test_scan_rotation();
    test_lock();
    test_release();
    test_multi_row();
    test_reset_in_lock();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
